load_store_unit: RTL and testbench

- Memory stage downstream of the ALU. Consumes the ALU-computed effective address and rs2 data for RV32I loads and stores.
- Drives a req/gnt/rvalid data-memory port and returns aligned, sign- or zero-extended load data to the register write-back path.
- Asserts busy so the ProgramCounter enable can stall the core while an access is in flight.

---
 rtl/load_store_unit_pkg.sv | 26 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states and RV32I
// load/store funct3 encodings.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } L_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } S_funct3_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load
// extraction/extension and legality of funct3/alignment.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata,
    output logic        illegal
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    // Decode size, lanes and extension; unsigned forms exist only for loads
    always_comb begin
        be        = '0;
        wdata_rep = '0;
        ldata     = '0;
        illegal   = 1'b0;
        case (funct3)
            lb, lbu: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                ldata     = {{24{lane[7] & ~funct3[2]}}, lane[7:0]};
            end
            lh, lhu: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                ldata     = {{16{lane[15] & ~funct3[2]}}, lane[15:0]};
                illegal   = addr_lo[0];
            end
            lw: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                ldata     = rdata;
                illegal   = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
        if (store && funct3[2]) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a req/gnt/rvalid data port.
// Optional watchdog on REQ/WAIT enabled by LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_we,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [4:0]  rd_q;
    logic        idle;

    logic [2:0]  a_f3;
    logic [1:0]  a_lo;
    logic        a_store;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] a_ldata;
    logic        a_illegal;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
    logic             expired;
    assign expired = (cnt == CNT_LAST);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign idle      = (state == IDLE);
    assign req_ready = idle;
    assign busy      = ~idle;

    // Aligner sees the live request in IDLE, the captured op afterwards
    assign a_f3    = idle ? req_funct3    : f3_q;
    assign a_lo    = idle ? req_addr[1:0] : lo_q;
    assign a_store = idle ? req_store     : store_q;

    lsu_align u_align (
        .funct3    (a_f3),
        .addr_lo   (a_lo),
        .store     (a_store),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .ldata     (a_ldata),
        .illegal   (a_illegal)
    );

    // Access FSM with capture registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            f3_q       <= '0;
            lo_q       <= '0;
            rd_q       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_we    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        f3_q      <= req_funct3;
                        lo_q      <= req_addr[1:0];
                        rd_q      <= req_rd;
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= a_be;
                        mem_wdata <= a_wdata;
                        if (a_illegal) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rd    <= req_rd;
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            mem_we  <= req_store;
`ifdef LSU_TIMEOUT_EN
                            cnt     <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (store_q) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_rd    <= rd_q;
                        end else begin
                            state <= WAIT;
`ifdef LSU_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (expired) begin
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rd    <= rd_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_we    <= 1'b1;
                        resp_data  <= a_ldata;
                        resp_rd    <= rd_q;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (expired) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rd    <= rd_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level timeline model
// with directed and randomized loads/stores.
module tb_load_store_unit;

    localparam int MAXC = 8192;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_we;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_we    (resp_we),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          busy;
        bit          mreq;
        bit          mwe;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        bit          wchk;
        logic [31:0] mwd;
        bit          rv;
        bit          rerr;
        logic [31:0] rdat;
        logic [4:0]  rrd;
        bit          rwe;
    } exp_t;

    exp_t ex [MAXC];
    int errors = 0;
    int checks = 0;

    task automatic cmp(string nm, int c, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, c, act, want);
        end
    endtask

    // ---- reference model: spec rules in plain arithmetic ----
    function automatic int m_size(logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_legal(bit st, logic [2:0] f3, logic [31:0] addr);
        bit ok;
        int lo;
        lo = int'(addr[1:0]);
        ok = st ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
        if (lo % m_size(f3) != 0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] addr);
        int m;
        m = ((1 << m_size(f3)) - 1) << int'(addr[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] m_wrep(logic [2:0] f3, logic [31:0] wd);
        case (m_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] addr,
                                           logic [31:0] rdw);
        longint v;
        int sz;
        sz = m_size(f3);
        v = longint'(rdw >> (8 * int'(addr[1:0])));
        if (sz < 4) begin
            v = v & ((longint'(1) << (8 * sz)) - 1);
            if (!f3[2] && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
        end
        return 32'(v);
    endfunction

    // ---- per-cycle compare against the predicted timeline ----
    always @(negedge clk) begin : compare
        int c;
        c = cyc;
        if (c < MAXC && ex[c].chk) begin
            cmp("busy", c, 32'(busy), 32'(ex[c].busy));
            cmp("req_ready", c, 32'(req_ready), 32'(!ex[c].busy));
            cmp("mem_req", c, 32'(mem_req), 32'(ex[c].mreq));
            if (ex[c].mreq) begin
                cmp("mem_we", c, 32'(mem_we), 32'(ex[c].mwe));
                cmp("mem_addr", c, mem_addr, ex[c].maddr);
                cmp("mem_be", c, 32'(mem_be), 32'(ex[c].mbe));
                if (ex[c].wchk) cmp("mem_wdata", c, mem_wdata, ex[c].mwd);
            end
            cmp("resp_valid", c, 32'(resp_valid), 32'(ex[c].rv));
            if (ex[c].rv) begin
                cmp("resp_err", c, 32'(resp_err), 32'(ex[c].rerr));
                cmp("resp_data", c, resp_data, ex[c].rdat);
                cmp("resp_rd", c, 32'(resp_rd), 32'(ex[c].rrd));
            end
            cmp("resp_we", c, 32'(resp_we), 32'(ex[c].rv && ex[c].rwe));
            if (ex[c].rst) begin
                cmp("rst_mem_we", c, 32'(mem_we), 32'd0);
                cmp("rst_mem_addr", c, mem_addr, 32'd0);
                cmp("rst_mem_be", c, 32'(mem_be), 32'd0);
                cmp("rst_mem_wdata", c, mem_wdata, 32'd0);
                cmp("rst_resp_err", c, 32'(resp_err), 32'd0);
                cmp("rst_resp_data", c, resp_data, 32'd0);
                cmp("rst_resp_rd", c, 32'(resp_rd), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // One op: predict its whole timeline, then drive it cycle by cycle.
    // g = REQ cycles before gnt, r = cycles from gnt to rvalid (>=1).
    task automatic do_op(bit st, logic [2:0] f3, logic [31:0] addr,
                         logic [31:0] wd, logic [4:0] rd, logic [31:0] rdw,
                         int g, int r, bit tmo);
        int a, resp, gc, rc, mend;
        bit ok, ld;
        a    = cyc;
        ok   = m_legal(st, f3, addr);
        ld   = ok && !st && !tmo;
        gc   = a + 1 + g;
        rc   = gc + r;
        mend = tmo ? a + TMO : gc;
        if (!ok) resp = a + 1;
        else if (tmo) resp = a + 1 + TMO;
        else if (st) resp = gc + 1;
        else resp = rc + 1;
        for (int c = a + 1; c <= resp; c++) begin
            ex[c].busy = 1'b1;
            if (ok && c <= mend) begin
                ex[c].mreq  = 1'b1;
                ex[c].mwe   = st;
                ex[c].maddr = addr & 32'hFFFF_FFFC;
                ex[c].mbe   = m_be(f3, addr);
                ex[c].wchk  = st;
                ex[c].mwd   = m_wrep(f3, wd);
            end
        end
        ex[resp].rv   = 1'b1;
        ex[resp].rerr = !ok || tmo;
        ex[resp].rdat = ld ? m_load(f3, addr, rdw) : 32'd0;
        ex[resp].rrd  = rd;
        ex[resp].rwe  = ld;

        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        mem_gnt    = 1'b0;
        mem_rvalid = ($urandom % 4 == 0);
        mem_rdata  = $urandom;
        tick();
        for (int c = a + 1; c <= resp; c++) begin
            req_valid  = ($urandom % 2 == 1);
            req_store  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_rd     = 5'($urandom);
            mem_gnt    = ok && !tmo && (c == gc);
            if (ld && c == rc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdw;
            end else if (ld && c > gc && c < rc) begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end else begin
                mem_rvalid = ($urandom % 4 == 0);
                mem_rdata  = $urandom;
            end
            tick();
        end
        clear_in();
    endtask

    // Load abandoned by a reset while waiting for rvalid
    task automatic reset_mid();
        int a;
        a = cyc;
        ex[a + 1].busy  = 1'b1;
        ex[a + 1].mreq  = 1'b1;
        ex[a + 1].maddr = 32'h200;
        ex[a + 1].mbe   = 4'hF;
        ex[a + 2].busy  = 1'b1;
        ex[a + 3].busy  = 1'b1;
        ex[a + 4].rst   = 1'b1;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = 32'h0;
        req_rd     = 5'd12;
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        tick();
    endtask

    logic [2:0] ldf [5];

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            ex[i] = '{default: 0};
            ex[i].chk = 1'b1;
        end
        ex[0].chk = 1'b0;
        for (int i = 1; i <= 3; i++) ex[i].rst = 1'b1;

        ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010;
        ldf[3] = 3'b100; ldf[4] = 3'b101;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rd     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        cmp("pin_lb", cyc, m_load(3'b000, 32'h102, 32'h12F4_5678), 32'hFFFF_FFF4);
        cmp("pin_lbu", cyc, m_load(3'b100, 32'h102, 32'h12F4_5678), 32'h0000_00F4);
        cmp("pin_lhu", cyc, m_load(3'b101, 32'h102, 32'h12F4_5678), 32'h0000_12F4);
        cmp("pin_sb_be", cyc, 32'(m_be(3'b000, 32'h103)), 32'h8);
        cmp("pin_sb_wd", cyc, m_wrep(3'b000, 32'hA5), 32'hA5A5_A5A5);
        cmp("pin_lw_mis", cyc, 32'(m_legal(1'b0, 3'b010, 32'h101)), 32'd0);

        do_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1, 32'h0, 0, 1, 1'b0);
        do_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd2, 32'h0, 0, 1, 1'b0);
        do_op(1'b0, 3'b000, 32'h102, 32'h0, 5'd3, 32'h12F4_5678, 0, 1, 1'b0);
        do_op(1'b0, 3'b100, 32'h102, 32'h0, 5'd4, 32'h12F4_5678, 0, 1, 1'b0);
        do_op(1'b0, 3'b101, 32'h102, 32'h0, 5'd5, 32'h12F4_5678, 0, 1, 1'b0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd6, 32'h0, 0, 1, 1'b0);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd7, 32'h0, 0, 1, 1'b0);
        do_op(1'b1, 3'b100, 32'h100, 32'h0, 5'd8, 32'h0, 0, 1, 1'b0);
        do_op(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd9, 32'h0, 5, 1, 1'b0);
        do_op(1'b0, 3'b010, 32'h104, 32'h0, 5'd10, 32'hCAFE_F00D, 5, 3, 1'b0);
        tick();
        reset_mid();
`ifdef LSU_TIMEOUT_EN
        do_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd11, 32'h0, 0, 1, 1'b1);
        do_op(1'b1, 3'b010, 32'h304, 32'h1, 5'd13, 32'h0, 0, 1, 1'b1);
`endif

        for (int n = 0; n < 300 && cyc < MAXC - 64; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] addr;
            st = 1'($urandom);
            if ($urandom % 5 != 0)
                f3 = st ? 3'($urandom % 3) : ldf[$urandom % 5];
            else
                f3 = 3'($urandom);
            addr = $urandom;
            if ($urandom % 3 != 0) begin
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                else if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end
            do_op(st, f3, addr, $urandom, 5'($urandom), $urandom,
                  int'($urandom % 5), 1 + int'($urandom % 4), 1'b0);
            repeat ($urandom % 3) tick();
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
